// File: rtl/player_bullet_ctrl.sv
// player_bullet_ctrl: player bullet pool with spawn, per-frame motion, hit retirement and raster draw
module player_bullet_ctrl #(
  parameter int          N_BULLETS    = 4,
  parameter int          COOLDOWN     = 8,
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter int          PADDLE_W     = 50,
  parameter int          PADDLE_H     = 20,
  parameter int          BULLET_W     = 4,
  parameter int          BULLET_H     = 16,
  parameter int          BULLET_SPEED = 16,
  parameter logic [23:0] BULLET_COLOR = 24'hFFFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      fire,
  input  logic [10:0]               paddle_x,
  input  logic                      hit_valid,
  input  logic [2:0]                hit_idx,
  input  logic [10:0]               pixel_x,
  input  logic [9:0]                pixel_y,
  output logic [N_BULLETS-1:0]      active,
  output logic [11*N_BULLETS-1:0]   bullet_x,
  output logic [10*N_BULLETS-1:0]   bullet_y,
  output logic                      shot_fired,
  output logic                      bullet_on,
  output logic [23:0]               bullet_color
);
  localparam int          CW      = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [10:0] X_OFF   = 11'(PADDLE_W / 2 - BULLET_W / 2);
  localparam logic [9:0]  Y_SPAWN = 10'(VRES - PADDLE_H - BULLET_H);
  logic                    fire_q;
  logic                    fire_pending;
  logic [CW-1:0]           cooldown;
  logic [N_BULLETS-1:0]    act_next;
  logic [11*N_BULLETS-1:0] x_next;
  logic [10*N_BULLETS-1:0] y_next;
  logic                    spawn;
  logic                    on_next;
  int                      tgt;
  assign bullet_color = BULLET_COLOR;
  // Kill, then move, then spawn into the lowest free slot of the post-move mask
  always_comb begin
    act_next = active;
    x_next   = bullet_x;
    y_next   = bullet_y;
    spawn    = 1'b0;
    tgt      = 0;
    for (int i = 0; i < N_BULLETS; i++)
      if (hit_valid && int'(hit_idx) == i) act_next[i] = 1'b0;
    if (frame_tick) begin
      for (int i = 0; i < N_BULLETS; i++)
        if (act_next[i]) begin
          if (bullet_y[10*i +: 10] >= 10'(BULLET_SPEED)) y_next[10*i +: 10] = bullet_y[10*i +: 10] - 10'(BULLET_SPEED);
          else act_next[i] = 1'b0;
        end
      spawn = fire_pending && cooldown == '0 && !(&act_next);
      for (int i = N_BULLETS - 1; i >= 0; i--)
        if (!act_next[i]) tgt = i;
      for (int i = 0; i < N_BULLETS; i++)
        if (spawn && tgt == i) begin
          act_next[i]         = 1'b1;
          x_next[11*i +: 11]  = paddle_x + X_OFF;
          y_next[10*i +: 10]  = Y_SPAWN;
        end
    end
  end
  // Raster hit test in 12-bit arithmetic so the right/bottom bounds never wrap
  always_comb begin
    on_next = 1'b0;
    for (int i = 0; i < N_BULLETS; i++)
      if (active[i] &&
          {1'b0, pixel_x} >= {1'b0, bullet_x[11*i +: 11]} &&
          {1'b0, pixel_x} <  {1'b0, bullet_x[11*i +: 11]} + 12'(BULLET_W) &&
          {2'b0, pixel_y} >= {2'b0, bullet_y[10*i +: 10]} &&
          {2'b0, pixel_y} <  {2'b0, bullet_y[10*i +: 10]} + 12'(BULLET_H))
        on_next = 1'b1;
    on_next = on_next && {1'b0, pixel_x} < 12'(HRES) && {2'b0, pixel_y} < 12'(VRES);
  end
  // State registers; fire_q resets high so a button held through reset does not fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_q       <= 1'b1;
      fire_pending <= 1'b0;
      cooldown     <= '0;
      active       <= '0;
      bullet_x     <= '0;
      bullet_y     <= '0;
      shot_fired   <= 1'b0;
      bullet_on    <= 1'b0;
    end else begin
      fire_q       <= fire;
      fire_pending <= spawn ? 1'b0 : (fire_pending | (fire & ~fire_q));
      cooldown     <= spawn ? CW'(COOLDOWN) : (frame_tick && cooldown != '0) ? cooldown - CW'(1) : cooldown;
      active       <= act_next;
      bullet_x     <= x_next;
      bullet_y     <= y_next;
      shot_fired   <= spawn;
      bullet_on    <= on_next;
    end
  end
endmodule

// File: tb/tb_player_bullet_ctrl.sv
// tb_player_bullet_ctrl: self-checking bench for player_bullet_ctrl
module tb_player_bullet_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        frame_tick = 0;
  logic        fire = 0;
  logic [10:0] paddle_x = 0;
  logic        hit_valid = 0;
  logic [2:0]  hit_idx = 0;
  logic [10:0] pixel_x = 0;
  logic [9:0]  pixel_y = 0;
  logic [3:0]  active, z_active;
  logic [43:0] bullet_x, z_bullet_x;
  logic [39:0] bullet_y, z_bullet_y;
  logic        shot_fired, z_shot, bullet_on, z_on;
  logic [23:0] bullet_color, z_color;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [10:0] px;
    logic [9:0]  py;
    logic        on;
  } vec_t;
  vec_t tbl[7];

  player_bullet_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire), .paddle_x(paddle_x),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .active(active), .bullet_x(bullet_x), .bullet_y(bullet_y), .shot_fired(shot_fired),
    .bullet_on(bullet_on), .bullet_color(bullet_color)
  );

  player_bullet_ctrl #(.COOLDOWN(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire), .paddle_x(paddle_x),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .active(z_active), .bullet_x(z_bullet_x), .bullet_y(z_bullet_y), .shot_fired(z_shot),
    .bullet_on(z_on), .bullet_color(z_color)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sel_val(input int s);
    case (s)
      0: return 64'(shot_fired);
      1: return 64'(active);
      2: return 64'(bullet_on);
      3: return 64'(z_shot);
      default: return 64'(z_active);
    endcase
  endfunction

  task automatic sb_push(input string name, input int sel, input logic [63:0] exp);
    sb_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, sel_val(e.sel), e.exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int sel, input logic exp_shot);
    sb_push("shot", sel, 64'(exp_shot));
    frame_tick = 1;
    clk1();
    frame_tick = 0;
    sb_check();
  endtask

  task automatic press();
    fire = 1;
    clk1();
    fire = 0;
    clk1();
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) clk1();
    rst_n = 1;
    repeat (2) clk1();
  endtask

  initial begin
    tbl[0] = '{11'd123, 10'd684, 1'b1};
    tbl[1] = '{11'd126, 10'd699, 1'b1};
    tbl[2] = '{11'd127, 10'd684, 1'b0};
    tbl[3] = '{11'd123, 10'd700, 1'b0};
    tbl[4] = '{11'd122, 10'd690, 1'b0};
    tbl[5] = '{11'd125, 10'd683, 1'b0};
    tbl[6] = '{11'd124, 10'd690, 1'b1};

    #1;
    repeat (2) clk1();
    check("rst_active", 64'(active), 64'h0);
    check("rst_x", 64'(bullet_x), 64'h0);
    check("rst_y", 64'(bullet_y), 64'h0);
    check("rst_shot", 64'(shot_fired), 64'h0);
    check("rst_on", 64'(bullet_on), 64'h0);
    check("color", 64'(bullet_color), 64'hFFFFFF);
    rst_n = 1;
    repeat (2) clk1();

    paddle_x = 100;
    press();
    tick(0, 1);
    check("ss_active", 64'(active), 64'h1);
    check("ss_x", 64'(bullet_x[10:0]), 64'd123);
    check("ss_y", 64'(bullet_y[9:0]), 64'd684);
    clk1();
    check("ss_shot_pulse", 64'(shot_fired), 64'h0);
    for (int k = 1; k <= 42; k++) begin
      tick(0, 0);
      check("exit_y", 64'(bullet_y[9:0]), 64'(684 - 16 * k));
      check("exit_active", 64'(active), 64'h1);
    end
    check("exit_x", 64'(bullet_x[10:0]), 64'd123);
    tick(0, 0);
    check("exit_gone", 64'(active), 64'h0);
    check("exit_others_x", 64'(bullet_x[43:11]), 64'h0);
    check("exit_others_y", 64'(bullet_y[39:10]), 64'h0);

    do_reset();
    for (int t = 1; t <= 20; t++) begin
      fire = ~fire;
      clk1();
      tick(0, t == 1 || t == 10 || t == 19);
      if (t == 1)  check("cd_act1", 64'(active), 64'h1);
      if (t == 10) check("cd_act10", 64'(active), 64'h3);
      if (t == 19) check("cd_act19", 64'(active), 64'h7);
    end
    check("cd_x1", 64'(bullet_x[21:11]), 64'd123);
    check("cd_y2", 64'(bullet_y[29:20]), 64'(684 - 16));

    fire = 1;
    rst_n = 0;
    #1;
    check("mid_active_async", 64'(active), 64'h0);
    check("mid_x", 64'(bullet_x), 64'h0);
    check("mid_y", 64'(bullet_y), 64'h0);
    check("mid_shot", 64'(shot_fired), 64'h0);
    check("mid_on", 64'(bullet_on), 64'h0);
    repeat (2) clk1();
    rst_n = 1;
    repeat (2) clk1();
    tick(0, 0);
    check("mid_hold_noshot", 64'(active), 64'h0);
    fire = 0;

    do_reset();
    for (int k = 0; k < 4; k++) begin
      press();
      tick(3, 1);
      check("pf_fill", 64'(z_active), 64'((1 << (k + 1)) - 1));
    end
    press();
    tick(3, 0);
    check("pf_full", 64'(z_active), 64'hF);
    tick(3, 0);
    hit_valid = 1;
    hit_idx = 5;
    clk1();
    hit_valid = 0;
    check("pf_oor_hit", 64'(z_active), 64'hF);
    hit_valid = 1;
    hit_idx = 2;
    tick(3, 1);
    hit_valid = 0;
    check("pf_respawn_act", 64'(z_active), 64'hF);
    check("pf_respawn_y2", 64'(z_bullet_y[29:20]), 64'd684);
    check("pf_slot0_y", 64'(z_bullet_y[9:0]), 64'd588);
    hit_valid = 1;
    hit_idx = 1;
    clk1();
    hit_valid = 0;
    check("pf_kill1", 64'(z_active), 64'hD);

    do_reset();
    paddle_x = 100;
    press();
    tick(0, 1);
    for (int i = 0; i < 7; i++) begin
      pixel_x = tbl[i].px;
      pixel_y = tbl[i].py;
      sb_push($sformatf("draw%0d", i), 2, 64'(tbl[i].on));
      clk1();
      sb_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_bullet_ctrl.md
# player_bullet_ctrl

Owns the pool of player bullets for the Space Invaders pipeline. It sits downstream of the paddle controller, using `paddle_x` and the fire button, and upstream of the enemy collision stage and the pixel mixer. It spawns bullets at the paddle tip, advances them once per frame, and retires them on screen exit or on a hit report. It also produces a registered per-pixel `bullet_on` for the video mixer.

## Interface
- `N_BULLETS`, 4: bullet slots, 1..8.
- `COOLDOWN`, 8: frame ticks a spawn must wait after the previous spawn.
- `HRES`/`VRES`/`PADDLE_W`/`PADDLE_H`/`BULLET_W`/`BULLET_H`/`BULLET_SPEED`/`BULLET_COLOR`: taken from `params`; values 1280/720/50/20/4/16/16/24'hFFFFFF.
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per frame, at vblank start.
- `fire`, in, 1: fire button level, already synchronised.
- `paddle_x`, in, 11: paddle left edge.
- `hit_valid`, in, 1: collision stage reports that a bullet hit something.
- `hit_idx`, in, 3: slot index for `hit_valid`.
- `pixel_x`, in, 11: current raster x.
- `pixel_y`, in, 10: current raster y.
- `active`, out, N_BULLETS: slot-live mask.
- `bullet_x`, out, 11*N_BULLETS: packed left edges, slot i at [11i+:11].
- `bullet_y`, out, 10*N_BULLETS: packed top edges, slot i at [10i+:10].
- `shot_fired`, out, 1: one-cycle pulse on each spawn.
- `bullet_on`, out, 1: raster pixel is inside a live bullet.
- `bullet_color`, out, 24: constant BULLET_COLOR.

## Operation
- **Fire capture**
  - `fire_q` registers `fire`; its reset value is 1, so a button held through reset does not fire.
  - A rising edge (`fire & ~fire_q`) sets `fire_pending`.
  - Edges while `fire_pending` is already set are dropped; there is no queue.
- **Per-cycle kill**
  - `hit_valid` with `hit_idx < N_BULLETS` clears `active[hit_idx]` that cycle.
  - An out-of-range `hit_idx` is ignored.
- **On `frame_tick`**, evaluated against the post-kill mask:
  1. **Move:** each active slot with `y >= BULLET_SPEED` gets `y -= BULLET_SPEED`. Otherwise the slot is cleared, because it left the screen. `x` is unchanged.
  2. **Spawn:** fires if `fire_pending`, `cooldown == 0`, and at least one slot is free after step 1.
     - Target is the lowest-index free slot.
     - `x = paddle_x + PADDLE_W/2 - BULLET_W/2` (paddle_x+23), 11-bit.
     - `y = VRES - PADDLE_H - BULLET_H` = 684.
     - Set `active`, clear `fire_pending`, load `cooldown = COOLDOWN`, pulse `shot_fired`.
     - A freshly spawned bullet is not moved on its spawn tick.
  3. **No spawn:** if `cooldown != 0`, decrement it. If spawn was blocked only by a full pool, `fire_pending` stays set.
- **Simultaneous events**
  - Kill and tick in the same cycle: the kill applies first, and the killed slot may be the spawn target on that same tick.
  - Kill and move to the same slot: the slot ends inactive.
- **Draw**
  - `bullet_on` is registered.
  - It is 1 if any active slot satisfies `x <= pixel_x < x+BULLET_W` and `y <= pixel_y < y+BULLET_H`.
  - Comparisons use 12-bit arithmetic so that `x+BULLET_W` cannot wrap.
- **Reset values:** `active` = 0, all `bullet_x`/`bullet_y` = 0, `fire_pending` = 0, `cooldown` = 0, `shot_fired` = 0, `bullet_on` = 0. Reset mid-flight kills every bullet immediately.

## Timing
- `active`, `bullet_x`, `bullet_y` and `shot_fired` update on the clock edge that samples `frame_tick` (or `hit_valid`). They are visible the next cycle.
- `bullet_on` has 1-cycle latency from `pixel_x`/`pixel_y`. The mixer must delay its own pixel coordinates by one cycle to match.
- Minimum gap between spawns is COOLDOWN+1 frame ticks (9 with default values).
- Flight life: from y=684, 42 moves bring the bullet to y=12. It is cleared on the 43rd tick after spawn.
- `fire` rise to spawn happens at the next `frame_tick` that meets the conditions, so latency is unbounded.

## Test plan
- **Single shot:** reset, `paddle_x`=100, pulse `fire`, then tick.
  - Required: `shot_fired` pulses, slot0 active, x=123, y=684.
  - After the next tick: y=668.
- **Exit:** keep ticking after the single shot.
  - Required: y=12 after tick 42, slot0 inactive after tick 43, no other slot changes.
- **Cooldown:** hold `fire` high and toggle it every frame.
  - Required: spawns only on ticks 1, 10, 19, with slots 0, 1, 2 in that order.
- **Pool full:** `COOLDOWN`=0, fill all 4 slots, then press `fire` again.
  - Required: no spawn, `fire_pending` held.
  - Then `hit_valid`, `hit_idx`=2 in the same cycle as a tick: slot2 is killed and respawned at y=684.
- **Draw:**
  - Bullet at (123,684): raster (123,684) and (126,699) give `bullet_on`=1 one cycle later.
  - Raster (127,684) and (123,700) give 0.
- **Reset mid-flight:** assert `rst_n`=0 with 3 bullets live.
  - Required: `active`=0 asynchronously, all outputs at reset values, and `fire` held through reset produces no shot.
